arb_mux_stage: RTL and testbench

//  Parametrised N:1 data multiplexer with a registered output stage and valid/ready handshakes.

---
 rtl/arb_mux_stage_pkg.sv | 14 +
 rtl/arb_mux_stage_if.sv | 30 +++
 rtl/arb_mux_stage_rr.sv | 41 ++++
 rtl/arb_mux_stage.sv | 105 ++++++++++
 tb/tb_arb_mux_stage.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/arb_mux_stage_pkg.sv
// Shared arbitration constants and the select-width helper.
// Imported by the interface, the round-robin arbiter and the top.
package arb_pkg;

    localparam int ARB_EXT_SEL = 0;
    localparam int ARB_FIXED   = 1;
    localparam int ARB_RR      = 2;

    // Select width, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_stage_if.sv
// Request/response bundle for the shared-consumer mux stage.
// master: requesters + downstream consumer; slave: arb_mux_stage.
interface arb_mux_stage_if
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    localparam int SEL_W = clog2_min1(N_IN)
) ();

    logic [SEL_W-1:0]      sel;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_src;

    modport master (
        output sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/arb_mux_stage_rr.sv
// Combinational round-robin arbiter: rotate requests by ptr, then
// priority-encode. Ports: req, ptr in; gnt_idx, gnt_ok out.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_IN = 4,
    localparam int SEL_W = clog2_min1(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_ok
);

    localparam logic [SEL_W:0] NW = (SEL_W+1)'(N_IN);

    logic [2*N_IN-1:0] dbl;
    logic [N_IN-1:0]   rot;
    logic [SEL_W-1:0]  off;
    logic [SEL_W:0]    sum;

    always_comb begin
        // rot[0] is the request at ptr, rot[1] at ptr+1, ...
        dbl = {req, req} >> ptr;
        rot = dbl[N_IN-1:0];
        gnt_ok = 1'b0;
        off = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_ok = 1'b1;
                off = SEL_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NW) begin
            sum = sum - NW;
        end
        gnt_idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/arb_mux_stage.sv
// N:1 mux with registered output and valid/ready handshakes.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module arb_mux_stage
    import arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_IN     = 4,
    parameter int ARB_MODE = ARB_EXT_SEL,
    localparam int SEL_W   = clog2_min1(N_IN)
) (
    input logic            clk,
    input logic            rst,
    arb_mux_stage_if.slave bus
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_ok;
    logic [SEL_W-1:0] fix_idx;
    logic             fix_ok;
    logic             ext_ok;
    logic [SEL_W-1:0] gnt;
    logic             gnt_ok;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] gnt_data;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] src_q;

    rr_arbiter #(.N_IN(N_IN)) u_rr (
        .req     (bus.in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_idx),
        .gnt_ok  (rr_ok)
    );

    always_comb begin
        fix_ok = 1'b0;
        fix_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                fix_ok = 1'b1;
                fix_idx = SEL_W'(i);
            end
        end
    end

    // Out-of-range select simply yields no grant.
    always_comb begin
        ext_ok = 1'b0;
        if (int'(bus.sel) < N_IN) begin
            ext_ok = bus.in_valid[bus.sel];
        end
    end

    always_comb begin
        gnt = bus.sel;
        gnt_ok = ext_ok;
        if (ARB_MODE == ARB_FIXED) begin
            gnt = fix_idx;
            gnt_ok = fix_ok;
        end else if (ARB_MODE == ARB_RR) begin
            gnt = rr_idx;
            gnt_ok = rr_ok;
        end
    end

    assign load_en = !valid_q || bus.out_ready;
    assign xfer = !rst && load_en && gnt_ok;

    always_comb begin
        bus.in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (gnt == SEL_W'(i)) begin
                bus.in_ready[i] = xfer;
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q <= '0;
            src_q <= '0;
            rr_ptr <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q <= gnt_data;
            src_q <= gnt;
            if (ARB_MODE == ARB_RR) begin
                rr_ptr <= (gnt == SEL_W'(N_IN - 1)) ? '0 : gnt + 1'b1;
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data = data_q;
    assign bus.out_src = src_q;

endmodule

// File: tb/tb_arb_mux_stage.sv
// Scoreboard bench: three DUTs (ext-select, fixed, round-robin).
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_arb_mux_stage;
    import arb_pkg::*;

    typedef logic [33:0] beat_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    beat_t q_e[$];
    beat_t q_f[$];
    beat_t q_r[$];

    arb_mux_stage_if #(.WIDTH(32), .N_IN(4)) bus_e ();
    arb_mux_stage_if #(.WIDTH(32), .N_IN(4)) bus_f ();
    arb_mux_stage_if #(.WIDTH(32), .N_IN(4)) bus_r ();

    arb_mux_stage #(.WIDTH(32), .N_IN(4), .ARB_MODE(ARB_EXT_SEL)) u_e (
        .clk (clk),
        .rst (rst),
        .bus (bus_e)
    );

    arb_mux_stage #(.WIDTH(32), .N_IN(4), .ARB_MODE(ARB_FIXED)) u_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    arb_mux_stage #(.WIDTH(32), .N_IN(4), .ARB_MODE(ARB_RR)) u_r (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input int d, input logic [1:0] src,
                           input logic [31:0] data);
        beat_t b;
        int    n;
        case (d)
            0: n = q_e.size();
            1: n = q_f.size();
            default: n = q_r.size();
        endcase
        if (n == 0) begin
            tests++;
            fails++;
            $display("FAIL beat%0d: got unexpected src %0d data %h expected none",
                     d, src, data);
        end else begin
            case (d)
                0: b = q_e.pop_front();
                1: b = q_f.pop_front();
                default: b = q_r.pop_front();
            endcase
            chk($sformatf("src%0d", d), 32'(src), 32'(b[33:32]));
            chk($sformatf("data%0d", d), data, b[31:0]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_e.out_valid && bus_e.out_ready)
                pop_cmp(0, bus_e.out_src, bus_e.out_data);
            if (bus_f.out_valid && bus_f.out_ready)
                pop_cmp(1, bus_f.out_src, bus_f.out_data);
            if (bus_r.out_valid && bus_r.out_ready)
                pop_cmp(2, bus_r.out_src, bus_r.out_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] rr_seq[8];
        logic [1:0] rr_alt[4];
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus_e.sel = '0;
        bus_f.sel = '0;
        bus_r.sel = '0;
        bus_e.out_ready = 1'b1;
        bus_f.out_ready = 1'b1;
        bus_r.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_e.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
            bus_f.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
            bus_r.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
        end
        bus_e.in_valid = 4'hF;
        bus_f.in_valid = 4'hF;
        bus_r.in_valid = 4'hF;

        // Reset held with every channel requesting
        cyc();
        chk("rst in_ready e", 32'(bus_e.in_ready), 0);
        chk("rst in_ready f", 32'(bus_f.in_ready), 0);
        chk("rst in_ready r", 32'(bus_r.in_ready), 0);
        cyc();
        chk("rst out_valid e", 32'(bus_e.out_valid), 0);
        chk("rst out_data e", bus_e.out_data, 0);
        chk("rst out_src e", 32'(bus_e.out_src), 0);
        chk("rst out_valid r", 32'(bus_r.out_valid), 0);
        chk("rst in_ready e2", 32'(bus_e.in_ready), 0);

        // Release; external select walks 0..3
        bus_f.in_valid = 4'h0;
        bus_r.in_valid = 4'h0;
        rst = 1'b0;
        q_e.push_back({2'd0, 32'hA0});
        #1 chk("ext ready s0", 32'(bus_e.in_ready), 32'h1);
        cyc();
        chk("first beat valid", 32'(bus_e.out_valid), 1);
        chk("first beat data", bus_e.out_data, 32'hA0);
        for (int s = 1; s < 4; s++) begin
            bus_e.sel = 2'(s);
            q_e.push_back({2'(s), 32'hA0 + 32'(s)});
            #1 chk($sformatf("ext ready s%0d", s),
                   32'(bus_e.in_ready), 32'h1 << s);
            cyc();
        end
        bus_e.in_valid = 4'h0;
        cyc();

        // Fixed priority: ch1 beats ch3 until it drops
        bus_f.in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            q_f.push_back({2'd1, 32'hA1});
            #1 chk("fix ready ch1", 32'(bus_f.in_ready), 32'b0010);
            cyc();
        end
        bus_f.in_valid = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            q_f.push_back({2'd3, 32'hA3});
            #1 chk("fix ready ch3", 32'(bus_f.in_ready), 32'b1000);
            cyc();
        end
        bus_f.in_valid = 4'h0;
        cyc();

        // Round robin, all requesting, then 0101
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        rr_alt = '{2'd0, 2'd2, 2'd0, 2'd2};
        bus_r.in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            q_r.push_back({rr_seq[k], 32'hA0 + 32'(rr_seq[k])});
            #1 chk("rr ready all", 32'(bus_r.in_ready),
                   32'h1 << rr_seq[k]);
            cyc();
        end
        bus_r.in_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            q_r.push_back({rr_alt[k], 32'hA0 + 32'(rr_alt[k])});
            #1 chk("rr ready 0101", 32'(bus_r.in_ready),
                   32'h1 << rr_alt[k]);
            cyc();
        end

        // Back-pressure on a ch2 beat, then ch3 is next
        bus_r.in_data[2*32 +: 32] = 32'hDEAD;
        bus_r.in_valid = 4'b0100;
        q_r.push_back({2'd2, 32'hDEAD});
        #1 chk("rr ready dead", 32'(bus_r.in_ready), 32'b0100);
        cyc();
        bus_r.out_ready = 1'b0;
        bus_r.in_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall in_ready", 32'(bus_r.in_ready), 0);
            chk("stall valid", 32'(bus_r.out_valid), 1);
            chk("stall data", bus_r.out_data, 32'hDEAD);
            chk("stall src", 32'(bus_r.out_src), 2);
            cyc();
        end
        bus_r.out_ready = 1'b1;
        q_r.push_back({2'd3, 32'hA3});
        #1 chk("after stall ch3", 32'(bus_r.in_ready), 32'b1000);
        cyc();
        bus_r.in_valid = 4'h0;
        cyc();

        // Reset while a ch1 beat is stalled; beat is dropped
        bus_r.in_valid = 4'b0010;
        #1 chk("pre-rst ready ch1", 32'(bus_r.in_ready), 32'b0010);
        cyc();
        bus_r.out_ready = 1'b0;
        bus_r.in_valid = 4'h0;
        chk("held ch1 valid", 32'(bus_r.out_valid), 1);
        chk("held ch1 src", 32'(bus_r.out_src), 1);
        cyc();
        rst = 1'b1;
        cyc();
        chk("mid-rst valid", 32'(bus_r.out_valid), 0);
        chk("mid-rst src", 32'(bus_r.out_src), 0);
        rst = 1'b0;
        bus_r.out_ready = 1'b1;
        bus_r.in_valid = 4'hF;
        q_r.push_back({2'd0, 32'hA0});
        #1 chk("post-rst ch0", 32'(bus_r.in_ready), 32'b0001);
        cyc();
        bus_r.in_valid = 4'h0;
        cyc();
        cyc();

        chk("q_e drained", 32'(q_e.size()), 0);
        chk("q_f drained", 32'(q_f.size()), 0);
        chk("q_r drained", 32'(q_r.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
